// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        MEM_NONE    = 2'b00,
        MEM_WRITE   = 2'b01,
        MEM_READ    = 2'b10,
        MEM_ILLEGAL = 2'b11
    } mem_ctrl_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    typedef struct packed {
        mem_ctrl_e           ctrl;
        logic [DATA_W-1:0]   addr;
        logic [DATA_W-1:0]   wdata;
    } mem_req_t;

    // Misaligned, beyond the array, or an illegal opcode.
    function automatic logic access_error(input mem_req_t req, input int unsigned depth);
        return (req.addr[1:0] != 2'b00)
            || (32'(req.addr[DATA_W-1:2]) >= depth)
            || (req.ctrl == MEM_ILLEGAL);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the MEM stage (master) and the responder (slave).
interface dmem_responder_if
    import dmem_pkg::*;
#(
    parameter int unsigned TAG_W = 2
);
    logic                ReqValid;
    logic                ReqReady;
    mem_ctrl_e           MEMControl;
    logic [DATA_W-1:0]   Address;
    logic [DATA_W-1:0]   WriteData;
    logic [TAG_W-1:0]    WBControl;
    logic                RespValid;
    logic                RespReady;
    logic [DATA_W-1:0]   ReadData;
    logic [TAG_W-1:0]    WBControlOut;
    logic                Error;

    modport master (
        output ReqValid, MEMControl, Address, WriteData, WBControl, RespReady,
        input  ReqReady, RespValid, ReadData, WBControlOut, Error
    );

    modport slave (
        input  ReqValid, MEMControl, Address, WriteData, WBControl, RespReady,
        output ReqReady, RespValid, ReadData, WBControlOut, Error
    );

endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM; a read returns the contents before a same-edge write.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_en,
    input  logic                i_we,
    input  logic                i_re,
    input  logic [IDX_W-1:0]    i_addr,
    input  logic [DATA_W-1:0]   i_wdata,
    output logic [DATA_W-1:0]   o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Storage is deliberately left unreset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Every access refreshes the output word; non-reads return zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_en) begin
            r_rdata <= i_re ? r_mem[i_addr] : '0;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request, waits LATENCY cycles, commits, then
// holds the response (data, echoed WB tag, error) until the consumer takes it.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned TAG_W   = 2
) (
    input  logic             Clk,
    input  logic             Rst_n,
    dmem_responder_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    mem_req_t            r_req;
    mem_req_t            w_req_nxt;
    logic [TAG_W-1:0]    r_tag;
    logic [TAG_W-1:0]    w_tag_nxt;
    logic [TAG_W-1:0]    r_wb_out;
    logic [TAG_W-1:0]    w_wb_nxt;
    logic                r_error;
    logic                w_error_nxt;
    logic                r_req_ready;
    logic                r_resp_valid;

    logic                w_accept;
    logic                w_commit;
    logic                w_err;
    logic                w_we;
    logic                w_re;
    logic [DATA_W-1:0]   w_rdata;

    // Ready is registered, so the cycle right after reset never accepts.
    assign w_accept = r_req_ready && bus.ReqValid && (bus.MEMControl != MEM_NONE);
    assign w_err    = access_error(r_req, DEPTH);
    assign w_we     = w_commit && !w_err && (r_req.ctrl == MEM_WRITE);
    assign w_re     = w_commit && !w_err && (r_req.ctrl == MEM_READ);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req_nxt   = r_req;
        w_tag_nxt   = r_tag;
        w_wb_nxt    = r_wb_out;
        w_error_nxt = r_error;
        w_commit    = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_req_nxt.ctrl  = bus.MEMControl;
                    w_req_nxt.addr  = bus.Address;
                    w_req_nxt.wdata = bus.WriteData;
                    w_tag_nxt       = bus.WBControl;
                    w_cnt_nxt       = CNT_W'(LATENCY);
                    w_state_nxt     = WAIT;
                end
            end
            WAIT: begin
                // An exhausted counter marks the commit edge.
                if (r_cnt == '0) begin
                    w_commit    = 1'b1;
                    w_error_nxt = w_err;
                    w_wb_nxt    = r_tag;
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.RespReady) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request latches, counter and registered handshake/response outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cnt        <= '0;
            r_req        <= '0;
            r_tag        <= '0;
            r_wb_out     <= '0;
            r_error      <= 1'b0;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_req        <= w_req_nxt;
            r_tag        <= w_tag_nxt;
            r_wb_out     <= w_wb_nxt;
            r_error      <= w_error_nxt;
            r_req_ready  <= (w_state_nxt == IDLE);
            r_resp_valid <= (w_state_nxt == RESP);
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .i_clk   (Clk),
        .i_rst_n (Rst_n),
        .i_en    (w_commit),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_addr  (r_req.addr[IDX_W+1:2]),
        .i_wdata (r_req.wdata),
        .o_rdata (w_rdata)
    );

    assign bus.ReqReady     = r_req_ready;
    assign bus.RespValid    = r_resp_valid;
    assign bus.ReadData     = w_rdata;
    assign bus.WBControlOut = r_wb_out;
    assign bus.Error        = r_error;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=2 instance and a LATENCY=0 instance.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned LAT   = 2;
    localparam int unsigned TAG_W = 2;

    typedef struct packed {
        logic [31:0]      rdata;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0;
    exp_t e1;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    dmem_responder_if #(.TAG_W(TAG_W)) b0 ();
    dmem_responder_if #(.TAG_W(TAG_W)) b1 ();

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .TAG_W(TAG_W)) dut0 (
        .Clk(Clk), .Rst_n(Rst_n), .bus(b0.slave)
    );
    dmem_responder #(.DEPTH(DEPTH), .LATENCY(0), .TAG_W(TAG_W)) dut1 (
        .Clk(Clk), .Rst_n(Rst_n), .bus(b1.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitors: pop one expectation per completed response handshake.
    always @(negedge Clk) begin
        if (Rst_n && b0.RespValid && b0.RespReady) begin
            if (q0.size() == 0) begin
                check("sb0_unexpected_resp", 32'(q0.size()), 32'd1);
            end else begin
                e0 = q0.pop_front();
                check("sb0_rdata", b0.ReadData, e0.rdata);
                check("sb0_tag", 32'(b0.WBControlOut), 32'(e0.tag));
                check("sb0_err", 32'(b0.Error), 32'(e0.err));
            end
        end
    end

    always @(negedge Clk) begin
        if (Rst_n && b1.RespValid && b1.RespReady) begin
            if (q1.size() == 0) begin
                check("sb1_unexpected_resp", 32'(q1.size()), 32'd1);
            end else begin
                e1 = q1.pop_front();
                check("sb1_rdata", b1.ReadData, e1.rdata);
                check("sb1_tag", 32'(b1.WBControlOut), 32'(e1.tag));
                check("sb1_err", 32'(b1.Error), 32'(e1.err));
            end
        end
    end

    function automatic logic ready_of(input int sel);
        return (sel == 0) ? b0.ReqReady : b1.ReqReady;
    endfunction

    function automatic logic valid_of(input int sel);
        return (sel == 0) ? b0.RespValid : b1.RespValid;
    endfunction

    task automatic drive(input int sel, input logic v, input mem_ctrl_e ctrl,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [TAG_W-1:0] tag);
        if (sel == 0) begin
            b0.ReqValid = v; b0.MEMControl = ctrl; b0.Address = addr;
            b0.WriteData = wdata; b0.WBControl = tag;
        end else begin
            b1.ReqValid = v; b1.MEMControl = ctrl; b1.Address = addr;
            b1.WriteData = wdata; b1.WBControl = tag;
        end
    endtask

    // Issue one request; the expectation is queued at the accept edge.
    task automatic issue(input int sel, input mem_ctrl_e ctrl, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [TAG_W-1:0] tag,
                         input logic [31:0] exp_rd, input logic exp_err, input bit push,
                         output int acc_cyc);
        int n = 0;
        exp_t e;
        while (ready_of(sel) !== 1'b1 && n < 50) begin
            @(posedge Clk); #1;
            n++;
        end
        check("accept_wait", 32'(n < 50), 32'd1);
        drive(sel, 1'b1, ctrl, addr, wdata, tag);
        @(posedge Clk); #1;
        acc_cyc = cyc;
        drive(sel, 1'b0, MEM_NONE, 32'h0, 32'h0, '0);
        e.rdata = exp_rd;
        e.tag   = tag;
        e.err   = exp_err;
        if (push) begin
            if (sel == 0) q0.push_back(e);
            else          q1.push_back(e);
        end
    endtask

    task automatic wait_resp(input int sel, input int acc_cyc, input int exp_lat);
        int n = 0;
        while (valid_of(sel) !== 1'b1 && n < 40) begin
            @(posedge Clk); #1;
            n++;
        end
        check("resp_wait", 32'(n < 40), 32'd1);
        check("resp_latency", 32'(cyc - acc_cyc), 32'(exp_lat));
    endtask

    initial begin
        int acc;
        int n;
        drive(0, 1'b0, MEM_NONE, 32'h0, 32'h0, '0);
        drive(1, 1'b0, MEM_NONE, 32'h0, 32'h0, '0);
        b0.RespReady = 1'b1;
        b1.RespReady = 1'b1;

        // Reset values, and ReqReady rising only on the first edge after release.
        #12;
        check("rst_req_ready", 32'(b0.ReqReady), 32'd0);
        check("rst_resp_valid", 32'(b0.RespValid), 32'd0);
        check("rst_read_data", b0.ReadData, 32'd0);
        check("rst_wb_out", 32'(b0.WBControlOut), 32'd0);
        check("rst_error", 32'(b0.Error), 32'd0);
        Rst_n = 1'b1;
        #1;
        check("ready_before_edge", 32'(b0.ReqReady), 32'd0);
        @(posedge Clk); #1;
        check("ready_after_edge", 32'(b0.ReqReady), 32'd1);
        check("ready_after_edge_l0", 32'(b1.ReqReady), 32'd1);

        // Seed word 0, then write 8 to address 8 and read it back.
        issue(0, MEM_WRITE, 32'h0, 32'h1234_5678, 2'b01, 32'h0, 1'b0, 1'b1, acc);
        wait_resp(0, acc, LAT + 1);
        issue(0, MEM_WRITE, 32'h8, 32'h8, 2'b00, 32'h0, 1'b0, 1'b1, acc);
        wait_resp(0, acc, LAT + 1);
        issue(0, MEM_READ, 32'h8, 32'h0, 2'b10, 32'h8, 1'b0, 1'b1, acc);
        wait_resp(0, acc, LAT + 1);

        // Error cases: misaligned, out of range (no write), illegal opcode.
        issue(0, MEM_READ, 32'h2, 32'h0, 2'b11, 32'h0, 1'b1, 1'b1, acc);
        wait_resp(0, acc, LAT + 1);
        issue(0, MEM_WRITE, 32'(4 * DEPTH), 32'hDEAD, 2'b01, 32'h0, 1'b1, 1'b1, acc);
        wait_resp(0, acc, LAT + 1);
        issue(0, MEM_READ, 32'h0, 32'h0, 2'b00, 32'h1234_5678, 1'b0, 1'b1, acc);
        wait_resp(0, acc, LAT + 1);
        issue(0, MEM_ILLEGAL, 32'h4, 32'hFFFF, 2'b10, 32'h0, 1'b1, 1'b1, acc);
        wait_resp(0, acc, LAT + 1);

        // Null requests are never accepted.
        @(posedge Clk); #1;
        drive(0, 1'b1, MEM_NONE, 32'h8, 32'h99, 2'b11);
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk); #1;
            check("null_resp_valid", 32'(b0.RespValid), 32'd0);
            check("null_req_ready", 32'(b0.ReqReady), 32'd1);
        end
        drive(0, 1'b0, MEM_NONE, 32'h0, 32'h0, '0);

        // Backpressure: response held, a stray request pulse ignored.
        b0.RespReady = 1'b0;
        issue(0, MEM_READ, 32'h8, 32'h0, 2'b01, 32'h8, 1'b0, 1'b1, acc);
        wait_resp(0, acc, LAT + 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_read_data", b0.ReadData, 32'h8);
            check("bp_wb_out", 32'(b0.WBControlOut), 32'd1);
            check("bp_error", 32'(b0.Error), 32'd0);
            check("bp_req_ready", 32'(b0.ReqReady), 32'd0);
            check("bp_resp_valid", 32'(b0.RespValid), 32'd1);
            if (i == 1) drive(0, 1'b1, MEM_WRITE, 32'h8, 32'hBAD, 2'b10);
            if (i == 2) drive(0, 1'b0, MEM_NONE, 32'h0, 32'h0, '0);
            @(posedge Clk); #1;
        end
        b0.RespReady = 1'b1;
        issue(0, MEM_READ, 32'h8, 32'h0, 2'b11, 32'h8, 1'b0, 1'b1, acc);
        wait_resp(0, acc, LAT + 1);

        // Reset during WAIT aborts the write to address 12.
        issue(0, MEM_WRITE, 32'hC, 32'hAA, 2'b00, 32'h0, 1'b0, 1'b1, acc);
        wait_resp(0, acc, LAT + 1);
        issue(0, MEM_READ, 32'hC, 32'h0, 2'b10, 32'hAA, 1'b0, 1'b1, acc);
        wait_resp(0, acc, LAT + 1);
        issue(0, MEM_WRITE, 32'hC, 32'h55, 2'b01, 32'h0, 1'b0, 1'b0, acc);
        @(posedge Clk); #1;
        Rst_n = 1'b0;
        #1;
        check("abort_req_ready", 32'(b0.ReqReady), 32'd0);
        check("abort_resp_valid", 32'(b0.RespValid), 32'd0);
        check("abort_read_data", b0.ReadData, 32'd0);
        check("abort_wb_out", 32'(b0.WBControlOut), 32'd0);
        check("abort_error", 32'(b0.Error), 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        issue(0, MEM_READ, 32'hC, 32'h0, 2'b11, 32'hAA, 1'b0, 1'b1, acc);
        wait_resp(0, acc, LAT + 1);
        issue(0, MEM_WRITE, 32'hC, 32'h11, 2'b00, 32'h0, 1'b0, 1'b1, acc);
        wait_resp(0, acc, LAT + 1);
        issue(0, MEM_READ, 32'hC, 32'h0, 2'b01, 32'h11, 1'b0, 1'b1, acc);
        wait_resp(0, acc, LAT + 1);

        // Zero-latency build: response on the edge after accept.
        issue(1, MEM_WRITE, 32'h4, 32'h77, 2'b01, 32'h0, 1'b0, 1'b1, acc);
        wait_resp(1, acc, 1);
        issue(1, MEM_READ, 32'h4, 32'h0, 2'b10, 32'h77, 1'b0, 1'b1, acc);
        wait_resp(1, acc, 1);
        issue(1, MEM_READ, 32'h1000_0000, 32'h0, 2'b11, 32'h0, 1'b1, 1'b1, acc);
        wait_resp(1, acc, 1);

        // Drain: every queued expectation must have been matched.
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 20) begin
            @(posedge Clk); #1;
            n++;
        end
        check("drain_q0", 32'(q0.size()), 32'd0);
        check("drain_q1", 32'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
